// File: rtl/pwm.sv
// Fixed-period PWM generator. The period is STEP*MAX_DUTY clocks, and the high time
// is duty_q*STEP clocks measured from the start of each period.
module pwm #(
    parameter int STEP     = 10,
    parameter int MAX_DUTY = 10
) (
    input  logic [3:0] dutyMultiplier,
    input  logic       clk,
    input  logic       rst,
    output logic       pwm_out
);

    localparam int PERIOD = STEP * MAX_DUTY;
    localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int PW     = $clog2(PERIOD + 1);
    localparam int DW     = $clog2(MAX_DUTY + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
    localparam logic [DW-1:0] DUTY_MAX = DW'(MAX_DUTY);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] duty_q, duty_d;
    logic [PW-1:0] thresh;
    logic          wrap;

    always_comb begin
        wrap   = (cnt_q == CNT_LAST);
        cnt_d  = wrap ? '0 : cnt_q + CW'(1);
        duty_d = duty_q;
        // Sample the code only at the end of a period, so a change never glitches mid-period.
        if (wrap) begin
            if (32'(dutyMultiplier) > 32'(MAX_DUTY))
                duty_d = DUTY_MAX;
            else
                duty_d = DW'(dutyMultiplier);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            duty_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
        end
    end

    // The threshold width holds the full period, so the saturated code cannot overflow it.
    assign thresh  = PW'(duty_q) * PW'(STEP);
    assign pwm_out = (PW'(cnt_q) < thresh);

endmodule

// File: tb/tb_pwm.sv
// Randomized self-checking bench for pwm. It compares every clock against a period/duty
// reference model and also checks the per-period high-time totals.
module tb_pwm;

    localparam int STEP     = 10;
    localparam int MAX_DUTY = 10;
    localparam int PERIOD   = STEP * MAX_DUTY;

    logic       clk;
    logic       rst;
    logic [3:0] dutyMultiplier;
    logic       pwm_out;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference state: the position within the current period and the duty that applies to it
    int m_pos  = 0;
    int m_duty = 0;
    // Measurement of the observed waveform over the current period
    int  acc_hi  = 0;
    bit  seen_lo = 0;
    bit  contig  = 1;
    bit  full    = 0;

    pwm #(.STEP(STEP), .MAX_DUTY(MAX_DUTY)) dut (
        .dutyMultiplier(dutyMultiplier),
        .clk           (clk),
        .rst           (rst),
        .pwm_out       (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (pos %0d duty %0d t=%0t)",
                     tag, obs, exp, m_pos, m_duty, $time);
        end
    endtask

    function automatic int sat(input int code);
        return (code > MAX_DUTY) ? MAX_DUTY : code;
    endfunction

    // Apply one clock with the given inputs, advance the model, then check the output.
    task automatic step(input logic r, input logic [3:0] code);
        rst            = r;
        dutyMultiplier = code;
        @(posedge clk);
        if (!r) begin
            m_pos  = 0;
            m_duty = 0;
            full   = 0;
        end else if (m_pos == PERIOD - 1) begin
            m_duty = sat(int'(code));
            m_pos  = 0;
        end else begin
            m_pos++;
        end
        #1;
        chk("pwm_out", int'(pwm_out), (m_pos < m_duty * STEP) ? 1 : 0);
        if (r) begin
            if (m_pos == 0) begin
                acc_hi  = 0;
                seen_lo = 0;
                contig  = 1;
                full    = 1;
            end
            if (pwm_out) begin
                acc_hi++;
                if (seen_lo) contig = 0;
            end else begin
                seen_lo = 1;
            end
            if (full && m_pos == PERIOD - 1) begin
                chk("period_high", acc_hi, m_duty * STEP);
                chk("contiguous", int'(contig), 1);
            end
        end
    endtask

    task automatic run(input logic [3:0] code, input int n);
        for (int i = 0; i < n; i++) step(1'b1, code);
    endtask

    task automatic run_to_pos(input logic [3:0] code, input int pos);
        for (int i = 0; i < PERIOD && m_pos != pos; i++) step(1'b1, code);
    endtask

    initial begin
        rst            = 1'b0;
        dutyMultiplier = 4'bxxxx;

        // Reset held with an unknown code, then one full low period after release
        for (int i = 0; i < 10; i++) step(1'b0, 4'bxxxx);
        run(4'd7, PERIOD);

        // Sweep every legal code
        for (int c = 0; c <= MAX_DUTY; c++) run(4'(c), 256);

        // Mid-period change: the current period keeps code 3, the next one uses 7
        run_to_pos(4'd3, PERIOD - 1);
        run(4'd3, 1);
        run_to_pos(4'd3, 50);
        run(4'd7, 250);

        // Saturated code behaves like full duty; then the extremes
        run(4'd15, 300);
        run(4'd0, 300);
        run(4'd10, 300);

        // Mid-run reset with code 5
        run(4'd5, 200);
        run_to_pos(4'd5, 19);
        step(1'b0, 4'd5);
        run(4'd5, 250);

        // Randomized code changes and occasional reset bursts
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(9) == 0) begin
                int nr = $urandom_range(3, 1);
                for (int k = 0; k < nr; k++) step(1'b0, 4'($urandom_range(15)));
            end
            run(4'($urandom_range(15)), $urandom_range(300, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm.md
PWM -- requirements
Module: pwm

Interface
REQ-001 SHALL have parameter STEP, default 10, meaning clock cycles of high time per duty unit; legal range 1..1000.
REQ-002 SHALL have parameter MAX_DUTY, default 10, meaning duty code giving 100 % duty; the PWM period is STEP*MAX_DUTY clocks (default 100).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low (0 = reset asserted, 1 = run).
REQ-005 SHALL have port dutyMultiplier, input, 4 bits, unsigned: duty code, duty = dutyMultiplier/MAX_DUTY.
REQ-006 SHALL have port pwm_out, output, 1 bit: PWM waveform.
REQ-007 SHALL use port order dutyMultiplier, clk, rst, pwm_out for positional instantiation.

Function
REQ-008 SHALL contain a period counter cnt, wide enough for STEP*MAX_DUTY-1, counting 0,1,...,STEP*MAX_DUTY-1 then wrapping to 0, advancing once per clock while rst=1.
REQ-009 SHALL contain a duty register duty_q that captures dutyMultiplier only on the clock edge where cnt = STEP*MAX_DUTY-1, so a new code takes effect at the start of the next period (no mid-period glitches).
REQ-010 SHALL saturate the captured value: codes greater than MAX_DUTY (11..15 at default) SHALL be stored as MAX_DUTY.
REQ-011 SHALL drive pwm_out = 1 when cnt < duty_q*STEP, else 0, decoded only from registered state (no combinational path from dutyMultiplier to pwm_out).
REQ-012 SHALL give, at default parameters, a period of 100 clocks with duty_q*10 high clocks at the start of each period, followed by 100-duty_q*10 low clocks.
REQ-013 SHALL hold pwm_out constant 0 for a whole period when duty_q = 0, and constant 1 for a whole period when duty_q = MAX_DUTY, with no one-cycle pulse or gap at the wrap.
REQ-014 SHALL treat changes of dutyMultiplier between capture edges, including X/unknown values, as don't-care.
REQ-015 SHALL compute the product duty_q*STEP at a width that cannot overflow for the maximum saturated code.

Reset
REQ-016 SHALL, on any rising clk edge with rst=0, set cnt=0 and duty_q=0, overriding counting and capture.
REQ-017 SHALL therefore hold pwm_out=0 throughout reset and for the first full period after rst rises, regardless of dutyMultiplier.
REQ-018 SHALL restart the period from cnt=0 when reset is asserted mid-period; the previous duty is discarded.
REQ-019 SHALL start counting on the first rising edge with rst=1 (cnt = 1 after that edge).

Verification
REQ-020 Reset: rst=0 for 10 clocks, dutyMultiplier=X -> pwm_out=0, cnt=0 every cycle; after release pwm_out=0 for 100 clocks.
REQ-021 Sweep: dutyMultiplier stepped 0..10, each held 256 clocks, rst=1 -> in every complete period after each capture, high count = 10*code (0,10,...,100) of 100, high time contiguous from period start.
REQ-022 Mid-period change: code 3 captured, change to 7 at cnt=50 -> current period still 30 high; next period 70 high.
REQ-023 Saturation: dutyMultiplier=15 -> pwm_out=1 for all 100 clocks of every following period, same as code 10.
REQ-024 Extremes at wrap: code 10 -> no 0 at cnt wrap 99->0; code 0 -> no 1 anywhere.
REQ-025 Mid-run reset: code 5 running, rst=0 for 1 clock at cnt=20 -> pwm_out=0 immediately, next period (100 clocks) low, then 50 high/50 low.
